// File: rtl/p09_breakout_pkg.sv
// Shared breakout brick-field constants and types, used by the brick store and the block painter.
package p09_breakout_pkg;

    localparam int unsigned BLOCKS_PER_ROW = 13;
    localparam int unsigned NUM_ROWS       = 15;
    localparam int unsigned TOTAL_BLOCKS   = BLOCKS_PER_ROW * NUM_ROWS;

    typedef logic [BLOCKS_PER_ROW-1:0] row_word_t;
    typedef logic [3:0]                row_idx_t;

endpackage

// File: rtl/p09_popcount13.sv
// Combinational population count of one 13-bit brick row word.
module p09_popcount13
    import p09_breakout_pkg::*;
(
    input  row_word_t   bits,
    output logic [3:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < BLOCKS_PER_ROW; i++) begin
            count = count + 4'(bits[i]);
        end
    end

endmodule

// File: rtl/p09_block_state_store.sv
// Brick-field state store: one bit per brick per row, row pointer driven by the painter,
// write-back that can only clear bricks, and a live remaining-brick counter.
module p09_block_state_store
    import p09_breakout_pkg::*;
#(
    parameter int unsigned BLOCKS_PER_ROW = p09_breakout_pkg::BLOCKS_PER_ROW,
    parameter int unsigned NUM_ROWS       = p09_breakout_pkg::NUM_ROWS,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      new_frame,
    input  logic                      restart_level,
    output logic [BLOCKS_PER_ROW-1:0] block_line_state,
    input  logic                      go_next_line,
    input  logic                      write_block_line_state,
    input  logic [BLOCKS_PER_ROW-1:0] new_block_line_state,
    output logic                      destroyed_valid,
    output logic [3:0]                destroyed_count,
    output logic [CNT_W-1:0]          blocks_remaining,
    output logic                      level_clear
);

    localparam logic [CNT_W-1:0] TotalCnt = CNT_W'(BLOCKS_PER_ROW * NUM_ROWS);

    logic [BLOCKS_PER_ROW-1:0] mem_q [NUM_ROWS];
    logic [BLOCKS_PER_ROW-1:0] mem_d [NUM_ROWS];
    row_idx_t                  row_ptr_q, row_ptr_d;
    logic [CNT_W-1:0]          remaining_q, remaining_d;
    logic                      level_clear_q, level_clear_d;
    logic                      destroyed_valid_q, destroyed_valid_d;
    logic [3:0]                destroyed_count_q, destroyed_count_d;

    logic [BLOCKS_PER_ROW-1:0] cur_row;
    logic [BLOCKS_PER_ROW-1:0] removed;
    logic [3:0]                removed_cnt;

    always_comb begin
        cur_row = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_ptr_q == row_idx_t'(r)) begin
                cur_row = mem_q[r];
            end
        end
    end

    // Only bricks still present can be removed, so the counter cannot underflow.
    assign removed = cur_row & ~new_block_line_state;

    p09_popcount13 u_popcount (
        .bits  (removed),
        .count (removed_cnt)
    );

    always_comb begin
        mem_d             = mem_q;
        row_ptr_d         = row_ptr_q;
        remaining_d       = remaining_q;
        level_clear_d     = level_clear_q;
        destroyed_valid_d = 1'b0;
        destroyed_count_d = '0;

        if (restart_level) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                mem_d[r] = '1;
            end
            row_ptr_d     = '0;
            remaining_d   = TotalCnt;
            level_clear_d = 1'b0;
        end else begin
            if (new_frame) begin
                row_ptr_d = '0;
            end else if (go_next_line) begin
                // Wrap so the painter's end-of-field load fetches row 0 for the next frame.
                row_ptr_d = (row_ptr_q == row_idx_t'(NUM_ROWS - 1)) ? '0 : row_ptr_q + 4'd1;
            end

            if (write_block_line_state) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    if (row_ptr_q == row_idx_t'(r)) begin
                        mem_d[r] = cur_row & new_block_line_state;
                    end
                end
                remaining_d       = remaining_q - CNT_W'(removed_cnt);
                level_clear_d     = (remaining_d == '0);
                destroyed_valid_d = (removed_cnt != 4'd0);
                destroyed_count_d = removed_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                mem_q[r] <= '1;
            end
            row_ptr_q         <= '0;
            remaining_q       <= TotalCnt;
            level_clear_q     <= 1'b0;
            destroyed_valid_q <= 1'b0;
            destroyed_count_q <= '0;
        end else begin
            mem_q             <= mem_d;
            row_ptr_q         <= row_ptr_d;
            remaining_q       <= remaining_d;
            level_clear_q     <= level_clear_d;
            destroyed_valid_q <= destroyed_valid_d;
            destroyed_count_q <= destroyed_count_d;
        end
    end

    assign block_line_state = cur_row;
    assign blocks_remaining = remaining_q;
    assign level_clear      = level_clear_q;
    assign destroyed_valid  = destroyed_valid_q;
    assign destroyed_count  = destroyed_count_q;

endmodule

// File: tb/tb_p09_block_state_store.sv
// Directed bench for the brick-field state store: vector table plus hand-written sequences.
module tb_p09_block_state_store;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_frame = 1'b0;
    logic        restart_level = 1'b0;
    logic [12:0] block_line_state;
    logic        go_next_line = 1'b0;
    logic        write_block_line_state = 1'b0;
    logic [12:0] new_block_line_state = '0;
    logic        destroyed_valid;
    logic [3:0]  destroyed_count;
    logic [7:0]  blocks_remaining;
    logic        level_clear;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    p09_block_state_store dut (
        .clk                    (clk),
        .rst                    (rst),
        .new_frame              (new_frame),
        .restart_level          (restart_level),
        .block_line_state       (block_line_state),
        .go_next_line           (go_next_line),
        .write_block_line_state (write_block_line_state),
        .new_block_line_state   (new_block_line_state),
        .destroyed_valid        (destroyed_valid),
        .destroyed_count        (destroyed_count),
        .blocks_remaining       (blocks_remaining),
        .level_clear            (level_clear)
    );

    typedef struct {
        logic        rst;
        logic        rl;
        logic        nf;
        logic        go;
        logic        wr;
        logic [12:0] nw;
        logic [12:0] e_bls;
        logic [7:0]  e_rem;
        logic        e_lc;
        logic        e_dv;
        logic [3:0]  e_dc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rl, logic nf, logic go, logic wr, logic [12:0] nw,
                                logic [12:0] bls, logic [7:0] rem, logic lc, logic dv,
                                logic [3:0] dc);
        vec_t v;
        v.rst = r; v.rl = rl; v.nf = nf; v.go = go; v.wr = wr; v.nw = nw;
        v.e_bls = bls; v.e_rem = rem; v.e_lc = lc; v.e_dv = dv; v.e_dc = dc;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the edge that takes them.
    task automatic cyc(input logic r, input logic rl, input logic nf, input logic go,
                       input logic wr, input logic [12:0] nw);
        rst = r; restart_level = rl; new_frame = nf; go_next_line = go;
        write_block_line_state = wr; new_block_line_state = nw;
        @(posedge clk);
        #1;
        rst = 1'b0; restart_level = 1'b0; new_frame = 1'b0; go_next_line = 1'b0;
        write_block_line_state = 1'b0;
    endtask

    task automatic check(input string name, input logic [12:0] bls, input logic [7:0] rem,
                         input logic lc, input logic dv, input logic [3:0] dc);
        total++;
        if ({block_line_state, blocks_remaining, level_clear, destroyed_valid, destroyed_count}
            !== {bls, rem, lc, dv, dc}) begin
            bad++;
            $display("FAIL %s: got bls=%h rem=%0d lc=%b dv=%b dc=%0d, want bls=%h rem=%0d lc=%b dv=%b dc=%0d",
                     name, block_line_state, blocks_remaining, level_clear, destroyed_valid,
                     destroyed_count, bls, rem, lc, dv, dc);
        end
    endtask

    task automatic go_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        // Table starts with row_ptr=0, all rows full, 195 bricks.
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 195, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 195, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 195, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,13'h1FFB, 13'h1FFB, 194, 0, 1, 1));
        vecs.push_back(mk(0,0,0,0,0,'0,     13'h1FFB, 194, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,13'h1FFB, 13'h1FFB, 194, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,13'h0000, 13'h0000, 182, 0, 1, 12));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 182, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,1,13'h1FF0, 13'h1FFF, 178, 0, 1, 4));
        vecs.push_back(mk(0,0,1,0,1,13'h0FFF, 13'h1FFF, 177, 0, 1, 1));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h0000, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FF0, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,13'h1FFF, 13'h1FF0, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h0FFF, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,1,1,0,'0,     13'h1FFF, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 177, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h0000, 177, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,1,13'h0000, 13'h1FFF, 195, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 195, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 195, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 195, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 195, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,0,'0,     13'h1FFF, 195, 0, 0, 0));

        // Reset held two cycles, then walk all 15 rows back to row 0.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("reset1", 13'h1FFF, 195, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("reset2", 13'h1FFF, 195, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
            check($sformatf("walk%0d", i), 13'h1FFF, 195, 0, 0, 0);
        end

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].rl, vecs[i].nf, vecs[i].go, vecs[i].wr, vecs[i].nw);
            check($sformatf("vec%0d", i), vecs[i].e_bls, vecs[i].e_rem, vecs[i].e_lc,
                  vecs[i].e_dv, vecs[i].e_dc);
        end

        // Painter sequence across the wrap: write row 14, step, load row 0.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFD);
        check("row0_hit", 13'h1FFD, 194, 0, 1, 1);
        go_n(14);
        check("at_row14", 13'h1FFF, 194, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFE);
        check("wrap_T", 13'h1FFE, 193, 0, 1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("wrap_T1", 13'h1FFD, 193, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("wrap_T2", 13'h1FFD, 193, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFF);
        check("no_set", 13'h1FFD, 193, 0, 0, 0);

        // Write together with new_frame at row 7 lands on row 7.
        go_n(7);
        check("at_row7", 13'h1FFF, 193, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 13'h1F7F);
        check("wr_nf", 13'h1FFD, 192, 0, 1, 1);
        go_n(7);
        check("row7_rd", 13'h1F7F, 192, 0, 0, 0);

        // Level clear from a freshly restarted field, writing and stepping together.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("restart", 13'h1FFF, 195, 0, 0, 0);
        for (int r = 0; r < 15; r++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 13'h0000);
            check($sformatf("clear%0d", r), (r == 14) ? 13'h0000 : 13'h1FFF,
                  8'(195 - 13 * (r + 1)), (r == 14), 1'b1, 4'd13);
        end
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 13'h0000);
        check("clear_again", 13'h0000, 0, 1, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("relevel", 13'h1FFF, 195, 0, 0, 0);

        // Reset arriving with a write strobe discards the write.
        go_n(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0000);
        check("rst_wr", 13'h1FFF, 195, 0, 0, 0);
        go_n(2);
        check("rst_row2", 13'h1FFF, 195, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
